// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI write/read out, one response back.
// Latency: command to AW/W or AR valid is 1 cycle; cmd_ready only in IDLE; response held until rsp_ready.
// Build option AXIL_MASTER_TIMEOUT_EN aborts a stalled transaction after TIMEOUT_CYCLES (rsp_resp=2'b11).
module axil_cmd_master #(
  parameter int ADDR_WIDTH     = 7,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    axi_aclk,
  input  logic                    axi_aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WADDR = 3'd1;
  localparam logic [2:0] WRESP = 3'd2;
  localparam logic [2:0] RADDR = 3'd3;
  localparam logic [2:0] RDATA = 3'd4;
  localparam logic [2:0] RSP   = 3'd5;

  if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("axil_cmd_master: DATA_WIDTH must be 32 and TIMEOUT_CYCLES at least 2");
  end

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  aw_done;
  logic                  w_done;
  logic                  timeout;

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = wstrb_q;

  // A channel counts as done if it already handshook or handshakes this cycle.
  assign aw_done = !m_axi_awvalid || m_axi_awready;
  assign w_done  = !m_axi_wvalid  || m_axi_wready;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int             TW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_cnt;
  logic          busy;

  assign busy    = (state == WADDR) || (state == WRESP) || (state == RADDR) || (state == RDATA);
  assign timeout = busy && (to_cnt == TO_LAST);

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn)                to_cnt <= '0;
    else if (cmd_valid && cmd_ready) to_cnt <= '0;
    else if (busy)                   to_cnt <= to_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else if (timeout) begin
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b1;
      rsp_resp      <= 2'b11;
      rsp_rdata     <= '0;
      state         <= RSP;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            if (cmd_write) begin
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              m_axi_bready  <= 1'b1;
              state         <= WADDR;
            end else begin
              m_axi_arvalid <= 1'b1;
              state         <= RADDR;
            end
          end
        end
        WADDR: begin
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            if (m_axi_bvalid) begin
              m_axi_bready <= 1'b0;
              rsp_resp     <= m_axi_bresp;
              rsp_rdata    <= '0;
              rsp_valid    <= 1'b1;
              state        <= RSP;
            end else begin
              state <= WRESP;
            end
          end
        end
        WRESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            rsp_resp     <= m_axi_bresp;
            rsp_rdata    <= '0;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end
        RADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RDATA;
          end
        end
        RDATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rsp_resp     <= m_axi_rresp;
            rsp_rdata    <= m_axi_rdata;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: behavioural AXI4-Lite slave with per-channel delays plus a memory-array reference model.
`timescale 1ns/1ps
module tb_axil_cmd_master;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_ready, cmd_write;
  logic [6:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [6:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  axil_cmd_master #(.ADDR_WIDTH(7), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs_ctrl();
    return {57'd0, cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready};
  endfunction
  function automatic logic [63:0] outs_data();
    return {rsp_rdata, wdata};
  endfunction
  function automatic logic [63:0] outs_addr();
    return {44'd0, awaddr, araddr, wstrb, rsp_resp};
  endfunction

  // Handshake monitor: values seen at each rising edge.
  logic aw_hs = 1'b0, w_hs = 1'b0, b_hs = 1'b0, ar_hs = 1'b0, r_hs = 1'b0;
  int n_aw_hi = 0, n_w_hi = 0, n_ar_hi = 0, n_b_hs = 0, n_rsp_hs = 0;
  always @(posedge clk) begin
    aw_hs <= awvalid && awready;
    w_hs  <= wvalid && wready;
    b_hs  <= bvalid && bready;
    ar_hs <= arvalid && arready;
    r_hs  <= rvalid && rready;
    if (awvalid) n_aw_hi <= n_aw_hi + 1;
    if (wvalid)  n_w_hi  <= n_w_hi + 1;
    if (arvalid) n_ar_hi <= n_ar_hi + 1;
    if (bvalid && bready)       n_b_hs   <= n_b_hs + 1;
    if (rsp_valid && rsp_ready) n_rsp_hs <= n_rsp_hs + 1;
  end

  // Behavioural slave: 32 words, addresses 0x60 and up answer SLVERR.
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [31:0] smem [32];
  initial begin
    logic aw_got, w_got, ar_got;
    logic [6:0] s_aw, s_ar;
    logic [31:0] s_wd;
    logic [3:0] s_ws;
    int c_aw, c_w, c_b, c_ar, c_r;
    for (int i = 0; i < 32; i++) smem[i] = 32'd0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    aw_got = 0; w_got = 0; ar_got = 0; s_aw = 0; s_ar = 0; s_wd = 0; s_ws = 0;
    c_aw = 0; c_w = 0; c_b = 0; c_ar = 0; c_r = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
        c_aw = 0; c_w = 0; c_b = 0; c_ar = 0; c_r = 0;
      end else begin
        if (awready) begin awready = 0; if (aw_hs) aw_got = 1; end
        else if (awvalid) begin
          if (c_aw >= aw_dly) begin awready = 1; s_aw = awaddr; c_aw = 0; end else c_aw++;
        end
        if (wready) begin wready = 0; if (w_hs) w_got = 1; end
        else if (wvalid) begin
          if (c_w >= w_dly) begin wready = 1; s_wd = wdata; s_ws = wstrb; c_w = 0; end else c_w++;
        end
        if (b_hs) bvalid = 0;
        else if (aw_got && w_got && !bvalid) begin
          if (c_b >= b_dly) begin
            c_b = 0; aw_got = 0; w_got = 0;
            if (s_aw >= 7'h60) bresp = 2'b10;
            else begin
              bresp = 2'b00;
              for (int i = 0; i < 4; i++)
                if (s_ws[i]) smem[s_aw[6:2]][8*i +: 8] = s_wd[8*i +: 8];
            end
            bvalid = 1;
          end else c_b++;
        end
        if (arready) begin arready = 0; if (ar_hs) ar_got = 1; end
        else if (arvalid) begin
          if (c_ar >= ar_dly) begin arready = 1; s_ar = araddr; c_ar = 0; end else c_ar++;
        end
        if (r_hs) begin rvalid = 0; rdata = $urandom; end
        else if (ar_got && !rvalid) begin
          if (c_r >= r_dly) begin
            c_r = 0; ar_got = 0;
            if (s_ar >= 7'h60) begin rresp = 2'b10; rdata = 32'd0; end
            else begin rresp = 2'b00; rdata = smem[s_ar[6:2]]; end
            rvalid = 1;
          end else c_r++;
        end
      end
    end
  end

  // Reference model: plain byte-merge memory, error region from address 96 upward.
  logic [31:0] mmem [32];
  task automatic model(input logic wr, input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] er, output logic [1:0] eresp);
    int idx;
    idx = int'(a) / 4;
    er = 32'd0;
    eresp = 2'b00;
    if (int'(a) >= 96) eresp = 2'b10;
    else if (wr) begin
      for (int i = 0; i < 4; i++)
        if (s[i]) mmem[idx] = (mmem[idx] & ~(32'hFF << (8*i))) | (d & (32'hFF << (8*i)));
    end else er = mmem[idx];
  endtask

  task automatic set_dly(input int aw, input int w, input int b, input int ar, input int r);
    aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
  endtask

  task automatic do_cmd(input string tag, input logic wr, input logic [6:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int hold, output logic [31:0] rd, output logic [1:0] rr);
    int aw0, w0, ar0, b0, r0, t;
    logic stable;
    aw0 = n_aw_hi; w0 = n_w_hi; ar0 = n_ar_hi; b0 = n_b_hs; r0 = n_rsp_hs;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    cmd_valid = 0; cmd_wdata = $urandom; cmd_addr = 7'($urandom); cmd_wstrb = 4'($urandom);
    chk({tag, "_cmd_ready_busy"}, cmd_ready, 0);
    t = 0;
    while (!rsp_valid && t < 200) begin @(negedge clk); t++; end
    chk({tag, "_rsp_seen"}, rsp_valid, 1);
    rd = rsp_rdata; rr = rsp_resp;
    stable = 1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_resp !== rr || cmd_ready !== 1'b0) stable = 0;
    end
    chk({tag, "_rsp_stable"}, stable, 1);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk({tag, "_rsp_drop"}, rsp_valid, 0);
    repeat (2) @(negedge clk);
    chk({tag, "_one_rsp"}, n_rsp_hs - r0, 1);
    chk({tag, "_aw_hi"}, n_aw_hi - aw0, wr ? aw_dly + 1 : 0);
    chk({tag, "_w_hi"}, n_w_hi - w0, wr ? w_dly + 1 : 0);
    chk({tag, "_ar_hi"}, n_ar_hi - ar0, wr ? 0 : ar_dly + 1);
    chk({tag, "_b_hs"}, n_b_hs - b0, wr ? 1 : 0);
  endtask

  typedef struct {
    logic wr; logic [6:0] a; logic [31:0] d; logic [3:0] s;
    int awd, wd, bd, ard, rdd, hold;
    logic [31:0] exp_rd; logic [1:0] exp_rr;
  } vec_t;

  initial begin
    vec_t tbl [8];
    logic [31:0] rd, er;
    logic [1:0] rr, err;
    int t, k;
    logic seen;

    tbl[0] = '{1'b1, 7'h00, 32'h0000_0080, 4'hF, 0, 0, 0, 0, 0, 0, 32'h0, 2'b00};
    tbl[1] = '{1'b0, 7'h00, 32'h0,         4'h0, 0, 0, 0, 0, 0, 0, 32'h0000_0080, 2'b00};
    tbl[2] = '{1'b1, 7'h04, 32'h1234_5678, 4'hF, 0, 3, 0, 0, 0, 0, 32'h0, 2'b00};
    tbl[3] = '{1'b1, 7'h04, 32'hAABB_CCDD, 4'h3, 2, 0, 2, 0, 0, 5, 32'h0, 2'b00};
    tbl[4] = '{1'b0, 7'h04, 32'h0,         4'h0, 0, 0, 0, 2, 3, 5, 32'h1234_CCDD, 2'b00};
    tbl[5] = '{1'b1, 7'h60, 32'hFFFF_FFFF, 4'hF, 1, 1, 1, 0, 0, 1, 32'h0, 2'b10};
    tbl[6] = '{1'b0, 7'h60, 32'h0,         4'h0, 0, 0, 0, 1, 1, 0, 32'h0, 2'b10};
    tbl[7] = '{1'b0, 7'h08, 32'h0,         4'h0, 0, 0, 0, 0, 0, 2, 32'h0, 2'b00};

    for (int i = 0; i < 32; i++) mmem[i] = 32'd0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;

    repeat (3) @(negedge clk);
    chk("reset_ctrl", outs_ctrl(), 0);
    chk("reset_data", outs_data(), 0);
    chk("reset_addr", outs_addr(), 0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    chk("post_reset_cmd_ready", cmd_ready, 1);

    for (int i = 0; i < 8; i++) begin
      set_dly(tbl[i].awd, tbl[i].wd, tbl[i].bd, tbl[i].ard, tbl[i].rdd);
      do_cmd($sformatf("vec%0d", i), tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].hold, rd, rr);
      model(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].s, er, err);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d_resp", i), rr, tbl[i].exp_rr);
    end

    // Command presented during a held response is taken only the cycle after the response handshake.
    set_dly(0, 0, 0, 0, 0);
    do_cmd("wr08", 1'b1, 7'h08, 32'h0000_0005, 4'hF, 0, rd, rr);
    model(1'b1, 7'h08, 32'h0000_0005, 4'hF, er, err);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 7'h08; cmd_wdata = 32'h0000_0009; cmd_wstrb = 4'hF;
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    cmd_write = 0; cmd_addr = 7'h08;
    t = 0;
    while (!rsp_valid && t < 100) begin @(negedge clk); t++; end
    seen = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cmd_ready !== 1'b0 || arvalid !== 1'b0 || rsp_valid !== 1'b1) seen = 0;
    end
    chk("hold_no_accept", seen, 1);
    model(1'b1, 7'h08, 32'h0000_0009, 4'hF, er, err);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("after_rsp_hs_ctrl", {cmd_ready, arvalid, rsp_valid}, 3'b100);
    @(negedge clk);
    cmd_valid = 0;
    chk("accept_next_cycle", {cmd_ready, arvalid}, 2'b01);
    t = 0;
    while (!rsp_valid && t < 100) begin @(negedge clk); t++; end
    model(1'b0, 7'h08, 32'h0, 4'h0, er, err);
    chk("held_read_rdata", rsp_rdata, er);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic w; logic [6:0] a; logic [31:0] d; logic [3:0] s;
      w = 1'($urandom); a = {5'($urandom_range(0, 31)), 2'b00}; d = $urandom; s = 4'($urandom);
      set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
      do_cmd($sformatf("rnd%0d", i), w, a, d, s, $urandom_range(0, 3), rd, rr);
      model(w, a, d, s, er, err);
      chk($sformatf("rnd%0d_rdata", i), rd, er);
      chk($sformatf("rnd%0d_resp", i), rr, err);
    end

    // Reset while waiting for B: everything clears, the write is lost.
    set_dly(0, 0, 8, 0, 0);
    k = n_rsp_hs;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 7'h0C; cmd_wdata = 32'h0000_0077; cmd_wstrb = 4'hF;
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    cmd_valid = 0;
    repeat (3) @(negedge clk);
    chk("wresp_bready", {bready, awvalid, wvalid}, 3'b100);
    #2 rst_n = 0;
    #1;
    chk("async_reset_ctrl", outs_ctrl(), 0);
    chk("async_reset_data", outs_data(), 0);
    chk("async_reset_addr", outs_addr(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    set_dly(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("reset_recover_ctrl", {cmd_ready, rsp_valid}, 2'b10);
    repeat (10) @(negedge clk);
    chk("reset_no_rsp", n_rsp_hs - k, 0);
    do_cmd("rd0c", 1'b0, 7'h0C, 32'h0, 4'h0, 0, rd, rr);
    model(1'b0, 7'h0C, 32'h0, 4'h0, er, err);
    chk("rd0c_rdata", rd, er);

    // Stalled AR: abort after TMO cycles when the timeout build is used, otherwise wait forever.
    set_dly(0, 0, 0, 100000, 0);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 7'h10;
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    @(posedge clk);
    #1 cmd_valid = 0;
    seen = 0; k = 0;
    for (int i = 1; i <= 3 * TMO && !seen; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin seen = 1; k = i; end
    end
`ifdef AXIL_MASTER_TIMEOUT_EN
    chk("tmo_seen", seen, 1);
    chk("tmo_cycles", k, TMO);
    chk("tmo_resp", rsp_resp, 2'b11);
    chk("tmo_rdata", rsp_rdata, 0);
    chk("tmo_valids_drop", {arvalid, rready}, 2'b00);
`else
    chk("no_tmo_rsp", seen, 0);
    chk("no_tmo_arvalid_held", arvalid, 1);
`endif
    @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    chk("final_idle", {cmd_ready, rsp_valid, arvalid}, 3'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
- AXI4-Lite single-outstanding master that converts simple command-port requests into AXI4-Lite write/read transactions.
- Sits directly upstream of the PWM/IRQ AXI4-Lite slave and drives its s00_axi_* channels.
- Returns the slave's response (BRESP, or RRESP plus RDATA) on a response port.
- Replaces ad-hoc bench-driven bus toggling with a synthesizable sequencer usable by a CPU stub or bench.

Parameters:
- ADDR_WIDTH, 7, AXI address width; matches slave register map.
- DATA_WIDTH, 32, data width; must be 32.
- TIMEOUT_CYCLES, 256, cycles before abort (optional feature only); must be ≥2.

Ports:
- axi_aclk  in  1  clock
- axi_aresetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  write strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  BRESP/RRESP; 2'b11 = timeout
- m_axi_awaddr  out  ADDR_WIDTH  write address
- m_axi_awvalid  out  1  AW valid
- m_axi_awready  in  1  AW ready
- m_axi_wdata  out  DATA_WIDTH  write data
- m_axi_wstrb  out  DATA_WIDTH/8  write strobes
- m_axi_wvalid  out  1  W valid
- m_axi_wready  in  1  W ready
- m_axi_bresp  in  2  write response
- m_axi_bvalid  in  1  B valid
- m_axi_bready  out  1  B ready
- m_axi_araddr  out  ADDR_WIDTH  read address
- m_axi_arvalid  out  1  AR valid
- m_axi_arready  in  1  AR ready
- m_axi_rdata  in  DATA_WIDTH  read data
- m_axi_rresp  in  2  read response
- m_axi_rvalid  in  1  R valid
- m_axi_rready  out  1  R ready

Behaviour:
- Clock/reset: single clock axi_aclk; axi_aresetn is asynchronous assert, active-low.
- Reset values: all *valid, *ready, rsp_* and address/data outputs = 0; state = IDLE.
- Protection: AWPROT/ARPROT are not driven by this block; tie them to 3'b000 at the slave.
- FSM states: IDLE, WADDR, WRESP, RADDR, RDATA, RSP.
- IDLE:
  - cmd_ready=1.
  - On handshake, register addr/wdata/wstrb.
  - Write → WADDR with awvalid=wvalid=1 next cycle; read → RADDR with arvalid=1 next cycle.
  - Command-to-valid latency is 1 cycle.
- WADDR:
  - AW and W complete independently.
  - awvalid drops the cycle after awready is sampled high; wvalid likewise after wready.
  - Leave when both are done; simultaneous completion is allowed.
  - bready=1 from WADDR entry, so a B arriving in the same cycle as the last AW/W handshake is accepted.
  - Go to RSP directly if B was taken, otherwise go to WRESP.
- WRESP: bready=1; on bvalid capture bresp, rsp_rdata=0 → RSP.
- RADDR: arvalid=1 until arready; then → RDATA, with rready asserted from the cycle after the AR handshake.
- RDATA: rready=1; on rvalid capture rdata/rresp → RSP.
- RSP:
  - rsp_valid=1; rsp_rdata/rsp_resp stay stable until rsp_ready.
  - On handshake → IDLE.
  - cmd_ready=0 throughout RSP, so only one command is in flight at a time.
- Valid rules: no valid is ever deasserted before its ready, and payload stays stable while its valid is high.
- Outstanding: AXI responses are never ignored; only one transaction outstanding.
- Reset mid-transaction: all valids drop immediately and the transaction is lost with no response.
- cmd_ready/cmd_valid does not combinationally depend on any AXI input.

Optional Feature:
- Macro: AXIL_MASTER_TIMEOUT_EN.
- Defined: a counter clears on entry to WADDR/RADDR and increments every cycle in WADDR/WRESP/RADDR/RDATA.
  - At TIMEOUT_CYCLES all AXI valids/readys drop, and the FSM goes to RSP with rsp_resp=2'b11, rsp_rdata=0.
  - This is a bench-only debug aid and knowingly violates AXI valid-hold.
- Undefined: no counter logic; the FSM waits indefinitely; rsp_resp=2'b11 is never produced.

Test Plan:
- Write 0x00, data 0x0000_0080, wstrb 0xF, slave ready immediately → awvalid/wvalid high exactly one cycle, rsp_resp=2'b00, rsp_rdata=0, slave reg0 reads back 0x80.
- Read 0x00 after the previous write → arvalid one cycle, rsp_rdata=0x0000_0080, rsp_resp=2'b00.
- wready delayed 3 cycles after awready → awvalid drops after its handshake, wvalid held stable 4 cycles, single B accepted, exactly one response.
- rsp_ready held low 5 cycles → rsp_valid and payload stable, cmd_ready=0; a new cmd_valid is not accepted until the cycle after the response handshake.
- Assert axi_aresetn low during WRESP → all outputs 0 asynchronously; after release, IDLE with cmd_ready=1 and no stale rsp_valid.
- With AXIL_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, arready tied 0 → rsp_valid at cycle 16 after arvalid rise, rsp_resp=2'b11; without the macro, no response ever appears.
